// File: rtl/core_tile_seq_if.sv
// Host/core-facing bundle of the tile sequencer: tile config and status on one side,
// the registered instruction word and the OFIFO-valid flag on the other.
interface core_tile_seq_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] wgt_base;
  logic [ADDR_W-1:0] act_base;
  logic [ADDR_W-1:0] psum_base;
  logic [ADDR_W-1:0] n_act;
  logic              accum_en;
  logic              ofifo_valid;
  logic [63:0]       inst;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output start, wgt_base, act_base, psum_base, n_act, accum_en, ofifo_valid,
    input  inst, busy, done, cfg_err
  );

  modport slave (
    input  start, wgt_base, act_base, psum_base, n_act, accum_en, ofifo_valid,
    output inst, busy, done, cfg_err
  );
endinterface

// File: rtl/core_tile_seq.sv
// Tile sequencer: kernel load, activation stream and OFIFO drain for the 8x8 core.
// Every instruction bit is decoded from the current state and registered into inst.
module core_tile_seq #(
  parameter int ROW         = 8,
  parameter int COL         = 8,
  parameter int OFIFO_DEPTH = 64,
  parameter int ADDR_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  core_tile_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_K_FETCH, S_K_LOAD, S_K_SETTLE, S_A_FETCH, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  localparam logic [63:0]       IDLE_WORD = 64'h0000_0001_000C_0000;
  localparam logic [ADDR_W-1:0] ROW_C     = ADDR_W'(ROW);
  localparam logic [ADDR_W-1:0] COL_C     = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] DEPTH_C   = ADDR_W'(OFIFO_DEPTH);

  localparam int B_REN_P = 35, B_ACC = 33, B_CEN_P = 32, B_WEN_P = 31, B_A_P = 20;
  localparam int B_CEN_X = 19, B_A_X = 7, B_OFIFO_RD = 6;
  localparam int B_L0_RD = 3, B_L0_WR = 2, B_EXEC = 1, B_LOAD = 0;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_half, w_half_nxt;
  logic [63:0]       r_inst, w_inst_nxt;
  logic              r_done, w_done_nxt;
  logic              r_cfg_err;
  logic [ADDR_W-1:0] r_wgt, r_act, r_psum, r_n;
  logic              r_accum;

  logic              w_accept;
  logic [ADDR_W-1:0] w_fetch_len, w_fetch_base;

  assign w_accept     = (r_state == S_IDLE) && bus.start;
  assign w_fetch_len  = (r_state == S_K_FETCH) ? ROW_C : r_n;
  assign w_fetch_base = (r_state == S_K_FETCH) ? r_wgt : r_act;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_half_nxt  = 1'b0;
    w_inst_nxt  = IDLE_WORD;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start) w_state_nxt = (bus.n_act == '0) ? S_DONE : S_K_FETCH;
      end
      S_K_FETCH, S_A_FETCH: begin
        // SRAM data returns one cycle after the read, so L0 writes trail reads by one.
        if (r_cnt < w_fetch_len) begin
          w_inst_nxt[B_CEN_X]             = 1'b0;
          w_inst_nxt[B_A_X +: ADDR_W]     = w_fetch_base + r_cnt;
        end
        if (r_cnt != '0) w_inst_nxt[B_L0_WR] = 1'b1;
        if (r_cnt == w_fetch_len) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == S_K_FETCH) ? S_K_LOAD : S_EXEC;
        end
      end
      S_K_LOAD: begin
        w_inst_nxt[B_L0_RD] = 1'b1;
        w_inst_nxt[B_LOAD]  = 1'b1;
        if (r_cnt == ROW_C - 1'b1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_K_SETTLE;
        end
      end
      S_K_SETTLE: begin
        if (r_cnt == COL_C - 1'b1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_A_FETCH;
        end
      end
      S_EXEC: begin
        w_inst_nxt[B_L0_RD] = 1'b1;
        w_inst_nxt[B_EXEC]  = 1'b1;
        if (r_cnt == r_n - 1'b1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // r_cnt is the vector index; r_half selects the read or write half of its slot.
        w_cnt_nxt = r_cnt;
        if (!r_half) begin
          if (bus.ofifo_valid) begin
            w_inst_nxt[B_CEN_P]         = 1'b0;
            w_inst_nxt[B_REN_P]         = r_accum;
            w_inst_nxt[B_A_P +: ADDR_W] = r_psum + r_cnt;
            w_half_nxt                  = 1'b1;
          end
        end else begin
          w_inst_nxt[B_CEN_P]         = 1'b0;
          w_inst_nxt[B_WEN_P]         = 1'b1;
          w_inst_nxt[B_OFIFO_RD]      = 1'b1;
          w_inst_nxt[B_ACC]           = r_accum;
          w_inst_nxt[B_A_P +: ADDR_W] = r_psum + r_cnt;
          w_cnt_nxt                   = r_cnt + 1'b1;
          if (r_cnt == r_n - 1'b1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_half    <= 1'b0;
      r_inst    <= IDLE_WORD;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_wgt     <= '0;
      r_act     <= '0;
      r_psum    <= '0;
      r_n       <= '0;
      r_accum   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_half  <= w_half_nxt;
      r_inst  <= w_inst_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_wgt     <= bus.wgt_base;
        r_act     <= bus.act_base;
        r_psum    <= bus.psum_base;
        r_accum   <= bus.accum_en;
        r_n       <= (bus.n_act > DEPTH_C) ? DEPTH_C : bus.n_act;
        r_cfg_err <= (bus.n_act == '0) || (bus.n_act > DEPTH_C);
      end
    end
  end

  assign bus.inst    = r_inst;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.cfg_err = r_cfg_err;

endmodule

// File: tb/tb_core_tile_seq.sv
// Bench for core_tile_seq: a trace-level model predicts inst/busy/done/cfg_err every cycle,
// and directed tiles pin sequence lengths, addresses and timing to hand-derived values.
module tb_core_tile_seq;

  localparam logic [63:0] IDLE = 64'h0000_0001_000C_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  core_tile_seq_if #(.ADDR_W(11)) bus ();

  core_tile_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: whole-tile trace as a queue of words ----------------
  typedef enum {M_IDLE, M_SEQ, M_DRAIN, M_DONE} mmode_t;
  mmode_t      m_mode = M_IDLE;
  logic [63:0] m_q[$];
  bit          m_err = 1'b0;
  int          m_n, m_k;
  bit          m_half, m_acc;
  logic [10:0] m_psum;
  logic [63:0] exp_inst = IDLE;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_cfg = 1'b0;

  function automatic logic [63:0] fetch_word(input logic [10:0] base, input int i, input int len);
    logic [63:0] w = IDLE;
    if (i < len) begin
      w[19]   = 1'b0;
      w[17:7] = base + 11'(i);
    end
    if (i >= 1) w[2] = 1'b1;
    return w;
  endfunction

  always @(posedge clk) begin
    logic [63:0] w;
    logic        d;
    if (reset) begin
      m_mode = M_IDLE;
      m_q.delete();
      m_err  = 1'b0;
      exp_inst = IDLE; exp_done = 1'b0; exp_busy = 1'b0; exp_cfg = 1'b0;
    end else begin
      w = IDLE;
      d = 1'b0;
      case (m_mode)
        M_IDLE: if (bus.start) begin
          m_err  = (bus.n_act == 0) || (bus.n_act > 64);
          m_n    = (bus.n_act > 64) ? 64 : int'(bus.n_act);
          m_psum = bus.psum_base;
          m_acc  = bus.accum_en;
          if (bus.n_act == 0) m_mode = M_DONE;
          else begin
            for (int i = 0; i <= 8; i++) m_q.push_back(fetch_word(bus.wgt_base, i, 8));
            for (int i = 0; i < 8; i++) m_q.push_back(IDLE | 64'h9);
            for (int i = 0; i < 8; i++) m_q.push_back(IDLE);
            for (int i = 0; i <= m_n; i++) m_q.push_back(fetch_word(bus.act_base, i, m_n));
            for (int i = 0; i < m_n; i++) m_q.push_back(IDLE | 64'hA);
            m_mode = M_SEQ;
          end
        end
        M_SEQ: begin
          w = m_q.pop_front();
          if (m_q.size() == 0) begin
            m_mode = M_DRAIN; m_k = 0; m_half = 1'b0;
          end
        end
        M_DRAIN: begin
          if (!m_half) begin
            if (bus.ofifo_valid) begin
              w[32] = 1'b0; w[35] = m_acc; w[30:20] = m_psum + 11'(m_k);
              m_half = 1'b1;
            end
          end else begin
            w[32] = 1'b0; w[31] = 1'b1; w[6] = 1'b1; w[33] = m_acc;
            w[30:20] = m_psum + 11'(m_k);
            m_half = 1'b0;
            m_k++;
            if (m_k == m_n) m_mode = M_DONE;
          end
        end
        M_DONE: begin
          d = 1'b1;
          m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
      exp_inst = w;
      exp_done = d;
      exp_busy = (m_mode != M_IDLE);
      exp_cfg  = m_err;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("inst", bus.inst, exp_inst);
      check("busy_done_cfg", {61'd0, bus.busy, bus.done, bus.cfg_err},
            {61'd0, exp_busy, exp_done, exp_cfg});
    end
  end

  // ---------------- tile driver with trace observation ----------------
  logic [10:0] xq[$];
  logic [10:0] pq[$];
  int n_load, n_exec, n_ren, n_accb, n_pmem, n_early, pairbad, first_pmem, done_cycle;

  // Start is high in cycle 1; sampling after the j-th following edge observes cycle j+1.
  task automatic run_tile(input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                          input logic [10:0] na, input bit acc, input int ofv_mode,
                          input int rst_at);
    logic [63:0] w;
    logic [10:0] last_rd;
    int cyc;
    xq.delete(); pq.delete();
    n_load = 0; n_exec = 0; n_ren = 0; n_accb = 0; n_pmem = 0;
    n_early = 0; pairbad = 0; first_pmem = 0; done_cycle = 0;
    last_rd = '0;
    @(posedge clk); #1;
    bus.wgt_base = wb; bus.act_base = ab; bus.psum_base = pb;
    bus.n_act = na; bus.accum_en = acc; bus.start = 1'b1;
    bus.ofifo_valid = (ofv_mode != 2);
    for (int j = 1; j <= 3000; j++) begin
      @(posedge clk); #1;
      cyc = j + 1;
      bus.start = (ofv_mode == 1 && j < 20) ? ($urandom_range(0, 3) == 0) : 1'b0;
      case (ofv_mode)
        0:       bus.ofifo_valid = 1'b1;
        1:       bus.ofifo_valid = ($urandom_range(0, 3) != 0);
        default: bus.ofifo_valid = (cyc >= 46);
      endcase
      reset = (rst_at == cyc);
      @(negedge clk);
      w = bus.inst;
      if (!w[19]) xq.push_back(w[17:7]);
      if (w[0]) n_load++;
      if (w[1]) n_exec++;
      if (w[6] && cyc <= 47) n_early++;
      if (!w[32]) begin
        n_pmem++;
        if (first_pmem == 0) first_pmem = cyc;
        if (!w[31]) begin
          if (w[35]) n_ren++;
          last_rd = w[30:20];
        end else begin
          pq.push_back(w[30:20]);
          if (w[33]) n_accb++;
          if (acc && w[30:20] != last_rd) pairbad++;
        end
      end
      if (bus.done) done_cycle = cyc;
      if (rst_at != 0 && cyc == rst_at + 1) begin
        check("rst_inst", bus.inst, IDLE);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
      end
      if (rst_at == 0 && done_cycle != 0) break;
      if (rst_at != 0 && cyc > rst_at + 60) break;
    end
    bus.start = 1'b0;
    reset = 1'b0;
    if (rst_at == 0) check("done_timeout", {63'd0, done_cycle != 0}, 64'd1);
  endtask

  initial begin
    logic [10:0] na;
    bus.start = 1'b0; bus.wgt_base = '0; bus.act_base = '0; bus.psum_base = '0;
    bus.n_act = '0; bus.accum_en = 1'b0; bus.ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 reset = 1'b0;

    // Idle after reset: literal idle word, not busy.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_inst", bus.inst, 64'h0000_0001_000C_0000);
      check("idle_busy", {63'd0, bus.busy}, 64'd0);
    end

    // Baseline tile, overwrite mode.
    run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b0, 0, 0);
    check("xmem_cnt", 64'(xq.size()), 64'd12);
    for (int i = 0; i < 12 && i < xq.size(); i++)
      check("xmem_addr", 64'(xq[i]), (i < 8) ? 64'(i) : 64'(16 + i - 8));
    check("load_cnt", 64'(n_load), 64'd8);
    check("exec_cnt", 64'(n_exec), 64'd4);
    check("pwr_cnt", 64'(pq.size()), 64'd4);
    for (int i = 0; i < 4 && i < pq.size(); i++) check("pwr_addr", 64'(pq[i]), 64'(i));
    check("done_cycle", 64'(done_cycle), 64'd45);

    // Accumulate mode.
    run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b1, 0, 0);
    check("ren_cnt", 64'(n_ren), 64'd4);
    check("acc_cnt", 64'(n_accb), 64'd4);
    check("rd_wr_pair", 64'(pairbad), 64'd0);
    check("done_cycle_acc", 64'(done_cycle), 64'd45);

    // OFIFO empty for the first 10 drain cycles.
    run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b0, 2, 0);
    check("no_early_ofrd", 64'(n_early), 64'd0);
    check("drain_resume", 64'(first_pmem), 64'd47);
    check("done_cycle_stall", 64'(done_cycle), 64'd55);

    // n_act = 0.
    run_tile(11'd5, 11'd9, 11'd3, 11'd0, 1'b0, 0, 0);
    check("cfg_err_zero", {63'd0, bus.cfg_err}, 64'd1);
    check("done_cycle_zero", 64'(done_cycle), 64'd3);
    check("no_access_zero", 64'(xq.size() + n_pmem), 64'd0);

    // n_act above OFIFO depth is clamped.
    run_tile(11'd100, 11'd300, 11'd40, 11'd100, 1'b0, 0, 0);
    check("cfg_err_big", {63'd0, bus.cfg_err}, 64'd1);
    check("exec_cnt_big", 64'(n_exec), 64'd64);

    // Activation address wrap.
    run_tile(11'd0, 11'd2046, 11'd0, 11'd4, 1'b0, 0, 0);
    check("wrap_cnt", 64'(xq.size()), 64'd12);
    if (xq.size() == 12) begin
      check("wrap_a0", 64'(xq[8]), 64'd2046);
      check("wrap_a1", 64'(xq[9]), 64'd2047);
      check("wrap_a2", 64'(xq[10]), 64'd0);
      check("wrap_a3", 64'(xq[11]), 64'd1);
    end

    // Reset in the second EXEC cycle (EXEC occupies cycles 32..35).
    run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b0, 0, 33);
    check("rst_no_done", 64'(done_cycle), 64'd0);

    // Randomised tiles with bursty OFIFO and stray starts while busy.
    for (int t = 0; t < 8; t++) begin
      if (t == 3) na = 11'd0;
      else if (t == 5) na = 11'($urandom_range(65, 200));
      else na = 11'($urandom_range(1, 70));
      run_tile(11'($urandom), 11'($urandom), 11'($urandom), na, 1'($urandom), 1, 0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
